// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one multi-cycle multiply or divide through a shared
// mult/div unit and stalls the pipeline while the operation is in flight.
//
// Ports
//   clock, reset           : sole clock; synchronous active-high reset
//   x_insn, x_valid        : execute-stage instruction and its valid flag
//   x_opA, x_opB           : forwarded rs / rt operands in execute
//   md_result,
//   md_exception,
//   md_ready               : response from the mult/div unit
//   md_operandA/B          : latched operands to the unit
//   md_ctrl_mult/div       : one-cycle start pulses to the unit
//   stall                  : freezes the front of the pipeline
//   md_done                : one-cycle completion strobe
//   md_res_out, md_rd,
//   md_exc                 : completion result, destination and exception flag
//   busy                   : controller not idle
module multdiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_insn,
  input  logic        x_valid,
  input  logic [31:0] x_opA,
  input  logic [31:0] x_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        md_done,
  output logic [31:0] md_res_out,
  output logic [4:0]  md_rd,
  output logic        md_exc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Last WAIT counter value before a forced exception completion.
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic        trigger_s;
  logic        wait_last_s;
  logic        stall_s;
  logic [5:0]  cnt_r;
  logic [31:0] opa_r;
  logic [31:0] opb_r;
  logic [4:0]  rd_r;
  logic        mult_r;
  logic        div_r;
  logic        done_r;
  logic [31:0] res_r;
  logic        exc_r;

  // Instruction fields outside opcode/rd/ALU-op carry no meaning here.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{x_insn[21:7], x_insn[1:0]};

  // Instruction decode and WAIT-exit condition.
  always_comb begin
    is_mul_s    = x_valid && (x_insn[31:27] == 5'b00000) && (x_insn[6:2] == 5'b00110);
    is_div_s    = x_valid && (x_insn[31:27] == 5'b00000) && (x_insn[6:2] == 5'b00111);
    trigger_s   = is_mul_s || is_div_s;
    wait_last_s = (cnt_r == TMO_LAST);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and stall; stall rises in the trigger cycle itself so the
  // instruction is held in X before START.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          state_nxt_s = START;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        stall_s     = 1'b1;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        stall_s = 1'b1;
        if (md_ready || wait_last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand/destination capture, start pulses, wait counter and completion.
  // The start pulse registers double as the latched op type: they are loaded
  // from the decode on the trigger and so are high exactly during START.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r  <= 6'd0;
      opa_r  <= 32'd0;
      opb_r  <= 32'd0;
      rd_r   <= 5'd0;
      mult_r <= 1'b0;
      div_r  <= 1'b0;
      done_r <= 1'b0;
      res_r  <= 32'd0;
      exc_r  <= 1'b0;
    end else begin
      mult_r <= 1'b0;
      div_r  <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            opa_r  <= x_opA;
            opb_r  <= x_opB;
            rd_r   <= x_insn[26:22];
            mult_r <= is_mul_s;
            div_r  <= is_div_s;
          end
        end
        START: begin
          cnt_r <= 6'd0;
        end
        WAIT: begin
          cnt_r <= cnt_r + 6'd1;
          // A ready in the timeout cycle still delivers the unit's result.
          if (md_ready) begin
            res_r  <= md_result;
            exc_r  <= md_exception;
            done_r <= 1'b1;
          end else if (wait_last_s) begin
            res_r  <= 32'd0;
            exc_r  <= 1'b1;
            done_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign md_operandA  = opa_r;
  assign md_operandB  = opb_r;
  assign md_ctrl_mult = mult_r;
  assign md_ctrl_div  = div_r;
  assign stall        = stall_s;
  assign md_done      = done_r;
  assign md_res_out   = res_r;
  assign md_rd        = rd_r;
  assign md_exc       = exc_r;
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] x_insn;
  logic        x_valid;
  logic [31:0] x_opA;
  logic [31:0] x_opB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        stall;
  logic        md_done;
  logic [31:0] md_res_out;
  logic [4:0]  md_rd;
  logic        md_exc;
  logic        busy;

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .x_insn(x_insn), .x_valid(x_valid),
    .x_opA(x_opA), .x_opB(x_opB), .md_result(md_result),
    .md_exception(md_exception), .md_ready(md_ready),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .stall(stall),
    .md_done(md_done), .md_res_out(md_res_out), .md_rd(md_rd),
    .md_exc(md_exc), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done_cyc = -100;
  int n_mult_seen = 0;
  int n_div_seen  = 0;
  int n_mult_exp  = 0;
  int n_div_exp   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] aluop);
    mk_insn = {opc, rd, 15'd0, aluop, 2'b00};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops expected completions and counts start pulses.
  always @(negedge clock) begin
    if (md_ctrl_mult) n_mult_seen++;
    if (md_ctrl_div)  n_div_seen++;
    if (md_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res_out", md_res_out, e.res);
        check("rd", {27'd0, md_rd}, {27'd0, e.rd});
        check("exc", {31'd0, md_exc}, {31'd0, e.exc});
        check("done_spacing", {31'd0, (cyc - last_done_cyc) >= 4}, 32'd1);
      end
      last_done_cyc = cyc;
    end
  end

  // One mul/div from trigger to IDLE; ready_at = WAIT cycle of md_ready (0 = never).
  task automatic run_op(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int ready_at, input logic [31:0] res,
                        input logic exc);
    int w;
    int stall_n;
    int exp_w;
    logic got;
    exp_t e;
    exp_w = (ready_at == 0) ? 40 : ready_at;
    e.res = (ready_at == 0) ? 32'd0 : res;
    e.rd  = rd;
    e.exc = (ready_at == 0) ? 1'b1 : exc;
    q.push_back(e);
    if (is_div) n_div_exp++; else n_mult_exp++;
    x_insn  = mk_insn(5'b00000, rd, is_div ? 5'b00111 : 5'b00110);
    x_valid = 1'b1;
    x_opA   = a;
    x_opB   = b;
    #1 check("stall_trigger", {31'd0, stall}, 32'd1);
    stall_n = 1;
    @(negedge clock);
    x_valid = 1'b0;
    x_insn  = 32'd0;
    x_opA   = 32'hDEAD_BEEF;
    x_opB   = 32'hCAFE_F00D;
    check("start_mult", {31'd0, md_ctrl_mult}, {31'd0, ~is_div});
    check("start_div", {31'd0, md_ctrl_div}, {31'd0, is_div});
    #1 stall_n += stall;
    w = 0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (md_done) begin
        got = 1'b1;
        break;
      end
      w++;
      md_ready     = (w == ready_at);
      md_result    = res;
      md_exception = exc;
      #1 stall_n += stall;
    end
    md_ready = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("wait_cycles", w, exp_w);
    check("stall_cycles", stall_n, 2 + exp_w);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("opA_held", md_operandA, a);
    check("opB_held", md_operandB, b);
    @(negedge clock);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; x_insn = 32'd0; x_valid = 1'b0; x_opA = 32'd0; x_opB = 32'd0;
    md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res", md_res_out, 32'd0);
    check("rst_opA", md_operandA, 32'd0);
    check("rst_done", {31'd0, md_done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(1'b0, 5'd3, 32'd6, 32'd7, 5, 32'd42, 1'b0);        // mul r3 = 42
    run_op(1'b1, 5'd5, 32'd100, 32'd0, 2, 32'd0, 1'b1);       // div by zero
    run_op(1'b0, 5'd7, 32'd9, 32'd9, 0, 32'd81, 1'b0);        // never ready
    run_op(1'b0, 5'd1, 32'd3, 32'd4, 1, 32'd12, 1'b0);        // back-to-back, minimal
    run_op(1'b0, 5'd2, 32'd4, 32'd5, 1, 32'd20, 1'b0);
    run_op(1'b1, 5'd0, 32'd15, 32'd3, 3, 32'd5, 1'b0);        // rd = 0
    run_op(1'b0, 5'd9, 32'd11, 32'd9, 40, 32'd99, 1'b0);      // ready in timeout cycle

    // Not triggers: invalid mul, then a valid add.
    x_insn = mk_insn(5'b00000, 5'd4, 5'b00110); x_valid = 1'b0;
    #1 check("novalid_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    check("novalid_busy", {31'd0, busy}, 32'd0);
    x_insn = mk_insn(5'b00000, 5'd4, 5'b00000); x_valid = 1'b1;
    #1 check("add_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    check("add_busy", {31'd0, busy}, 32'd0);
    check("add_pulse", {31'd0, md_ctrl_mult | md_ctrl_div}, 32'd0);
    x_valid = 1'b0;

    // Reset during WAIT abandons the operation; a later ready is ignored.
    x_insn = mk_insn(5'b00000, 5'd6, 5'b00110); x_valid = 1'b1;
    x_opA = 32'd5; x_opB = 32'd8;
    n_mult_exp++;
    @(negedge clock);
    x_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_opA", md_operandA, 32'd0);
    check("rst_mid_opB", md_operandB, 32'd0);
    check("rst_mid_rd", {27'd0, md_rd}, 32'd0);
    check("rst_mid_res", md_res_out, 32'd0);
    check("rst_mid_exc", {31'd0, md_exc}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    md_ready = 1'b1; md_result = 32'd40; md_exception = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("late_ready_done", {31'd0, md_done}, 32'd0);
    end
    md_ready = 1'b0;
    check("late_ready_busy", {31'd0, busy}, 32'd0);

    // Reset beats a trigger in the same cycle.
    x_insn = mk_insn(5'b00000, 5'd8, 5'b00111); x_valid = 1'b1; x_opA = 32'd77;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; x_valid = 1'b0;
    check("rst_trig_busy", {31'd0, busy}, 32'd0);
    check("rst_trig_div", {31'd0, md_ctrl_div}, 32'd0);
    check("rst_trig_opA", md_operandA, 32'd0);

    repeat (3) @(negedge clock);
    check("queue_empty", q.size(), 32'd0);
    check("mult_pulses", n_mult_seen, n_mult_exp);
    check("div_pulses", n_div_seen, n_div_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 40, meaning: WAIT-state cycles allowed before forcing an exception completion.
REQ-002 Port: clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: x_insn, input, 32, execute-stage instruction; opcode [31:27], rd [26:22], ALU op [6:2].
REQ-005 Port: x_valid, input, 1, execute-stage instruction is real (0 = bubble or flushed).
REQ-006 Port: x_opA, input, 32, forwarded rs operand in execute.
REQ-007 Port: x_opB, input, 32, forwarded rt operand in execute.
REQ-008 Port: md_result, input, 32, result from the shared mult/div unit.
REQ-009 Port: md_exception, input, 1, overflow / divide-by-zero flag from the unit.
REQ-010 Port: md_ready, input, 1, unit result-ready strobe.
REQ-011 Port: md_operandA, output, 32, latched operand A to the unit.
REQ-012 Port: md_operandB, output, 32, latched operand B to the unit.
REQ-013 Port: md_ctrl_mult, output, 1, one-cycle multiply start pulse.
REQ-014 Port: md_ctrl_div, output, 1, one-cycle divide start pulse.
REQ-015 Port: stall, output, 1, freezes PC, F/D, D/X latches; holds X.
REQ-016 Port: md_done, output, 1, one-cycle strobe; X/M latch captures md_res_out.
REQ-017 Port: md_res_out, output, 32, registered result.
REQ-018 Port: md_rd, output, 5, destination register of the operation in flight.
REQ-019 Port: md_exc, output, 1, completion is an exception (downstream writes $rstatus).
REQ-020 Port: busy, output, 1, FSM not in IDLE.

Function
REQ-021 Trigger: x_valid=1, opcode=00000, ALU op 00110 (mul) or 00111 (div); all other instructions are ignored.
REQ-022 FSM states IDLE, START, WAIT, DONE; reset and post-DONE state is IDLE.
REQ-023 IDLE on trigger: latch x_opA, x_opB, rd and op type; go to START; stall=1 combinationally in that cycle.
REQ-024 START: exactly one of md_ctrl_mult / md_ctrl_div =1 per latched op type for one cycle; clear counter; stall=1; go to WAIT.
REQ-025 WAIT: stall=1; 6-bit counter increments each cycle.
REQ-026 WAIT exit on md_ready=1: register md_result into md_res_out and md_exception into md_exc; go to DONE.
REQ-027 WAIT exit on counter=TIMEOUT-1 with md_ready=0: md_res_out=0, md_exc=1; go to DONE.
REQ-028 If md_ready=1 in the timeout cycle, ready wins.
REQ-029 DONE: md_done=1, stall=0; pipeline advances; go to IDLE.
REQ-030 md_ready and md_exception are ignored in IDLE, START and DONE.
REQ-031 md_operandA/B are held constant from START through DONE.
REQ-032 Back-to-back mul/div: the second trigger is accepted in the IDLE cycle after DONE; no lost or duplicated start pulse.
REQ-033 rd=0 is processed normally; md_rd=0 is reported and downstream suppresses the write.
REQ-034 Start pulses never both high; a start pulse is never issued outside START.
REQ-035 Minimum occupancy is 4 cycles (trigger, START, 1 WAIT, DONE).

Reset
REQ-036 reset=1 at an edge forces IDLE and sets counter, md_operandA/B, md_res_out, md_rd, md_exc, md_done, md_ctrl_mult, md_ctrl_div, stall and busy to 0.
REQ-037 Reset mid-operation abandons the operation with no md_done; a later md_ready is ignored.
REQ-038 Reset has priority over a trigger in the same cycle.

Verification
REQ-039 mul r3,r1,r2 with opA=6, opB=7, ready after 5 WAIT cycles, result 42 -> one md_ctrl_mult pulse; stall high 7 cycles; md_done with md_res_out=42, md_rd=3, md_exc=0.
REQ-040 div with opB=0, unit returns md_exception=1 -> md_done with md_exc=1; stall released the same cycle.
REQ-041 md_ready never asserted -> md_done at WAIT cycle 40 with md_exc=1, md_res_out=0.
REQ-042 Two consecutive mul instructions -> two separate start pulses and two md_done strobes, each ≥4 cycles apart.
REQ-043 reset asserted in WAIT, then md_ready=1 -> all outputs 0, no md_done, busy=0.
REQ-044 mul with x_valid=0, or an add -> no start pulse, stall=0.
